// File: rtl/key_debounce_pkg.sv
// Shared constants for the clock's push-button front end: key indices,
// 50 MHz timing defaults and the per-channel phase encoding.
package key_debounce_pkg;

   localparam int KEY_MODE = 0;
   localparam int KEY_SET  = 1;
   localparam int KEY_UP   = 2;
   localparam int KEY_DOWN = 3;

   localparam int NUM_KEYS_DEF = 4;
   localparam int DEB_CYC_DEF  = 1000000;   // 20 ms
   localparam int LONG_CYC_DEF = 50000000;  // 1 s
   localparam int RPT_CYC_DEF  = 10000000;  // 200 ms

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_REPEAT
   } key_phase_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce counter, hold counter
// and the idle/press-wait/repeat phase FSM, all outputs registered.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int DEB_CYC  = DEB_CYC_DEF,
   parameter int LONG_CYC = LONG_CYC_DEF,
   parameter int RPT_CYC  = RPT_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_repeat
);

   localparam int DEB_W  = $clog2(DEB_CYC + 1);
   localparam int HOLD_W = $clog2(max_int(LONG_CYC, RPT_CYC) + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
   localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(RPT_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

   logic              meta;
   logic              stab;
   logic              sync;
   logic              deb_accept;
   logic [DEB_W-1:0]  deb_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   key_phase_t        phase;

   // Sync flops reset to the released level so a held key is seen as a new press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         stab <= 1'b1;
      end else begin
         meta <= key_n;
         stab <= meta;
      end
   end

   assign sync       = ~stab;
   assign deb_accept = (sync != key_state) && (deb_cnt == DEB_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_state   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
         deb_cnt     <= '0;
         hold_cnt    <= '0;
         phase       <= ST_IDLE;
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
         if (deb_accept) begin
            // An accepted edge restarts hold timing and wins over any pending long/repeat
            key_state <= sync;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            if (sync) begin
               key_press <= 1'b1;
               phase     <= ST_PRESS_WAIT;
            end else begin
               key_release <= 1'b1;
               phase       <= ST_IDLE;
            end
         end else begin
            if (sync == key_state) begin
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
            if (key_state) begin
               case (phase)
                  ST_PRESS_WAIT: begin
                     if (hold_cnt == LONG_LAST) begin
                        key_long <= 1'b1;
                        hold_cnt <= '0;
                        phase    <= ST_REPEAT;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
                  ST_REPEAT: begin
                     // With repeat disabled the counter just parks at full scale
                     if (RPT_CYC == 0) begin
                        if (hold_cnt != HOLD_MAX) begin
                           hold_cnt <= hold_cnt + 1'b1;
                        end
                     end else if (hold_cnt == RPT_LAST) begin
                        key_repeat <= 1'b1;
                        hold_cnt   <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
                  default: begin
                     hold_cnt <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: NUM_KEYS independent channels producing debounced
// levels plus one-cycle press, release, long-press and auto-repeat pulses.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int NUM_KEYS = NUM_KEYS_DEF,
   parameter int DEB_CYC  = DEB_CYC_DEF,
   parameter int LONG_CYC = LONG_CYC_DEF,
   parameter int RPT_CYC  = RPT_CYC_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_repeat
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEB_CYC  (DEB_CYC),
         .LONG_CYC (LONG_CYC),
         .RPT_CYC  (RPT_CYC)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_n       (key_n[i]),
         .key_state   (key_state[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_long    (key_long[i]),
         .key_repeat  (key_repeat[i])
      );
   end

endmodule
